// File: rtl/mac_seq_ctrl_if.sv
// rtl/mac_seq_ctrl_if.sv - job, operand-stream, MAC and result signals of the MAC sequencer
// The slave modport is the sequencer's view; master is the surrounding system's view.
interface mac_seq_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int OUT_WIDTH  = 32,
   parameter int LEN_WIDTH  = 8
);
   logic                      start;
   logic [LEN_WIDTH-1:0]      len;
   logic [4:0]                shift;
   logic                      relu_en;
   logic                      busy;
   logic                      in_valid;
   logic                      in_ready;
   logic [4*DATA_WIDTH-1:0]   in_a;
   logic [4*DATA_WIDTH-1:0]   in_b;
   logic [4*DATA_WIDTH-1:0]   mac_a;
   logic [4*DATA_WIDTH-1:0]   mac_b;
   logic [OUT_WIDTH-1:0]      mac_result;
   logic                      out_valid;
   logic                      out_ready;
   logic [OUT_WIDTH-1:0]      out_acc;
   logic [DATA_WIDTH-1:0]     out_q;

   modport slave (
      input  start, len, shift, relu_en, in_valid, in_a, in_b, mac_result, out_ready,
      output busy, in_ready, mac_a, mac_b, out_valid, out_acc, out_q
   );

   modport master (
      output start, len, shift, relu_en, in_valid, in_a, in_b, mac_result, out_ready,
      input  busy, in_ready, mac_a, mac_b, out_valid, out_acc, out_q
   );
endinterface

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - dot-product job sequencer and accumulator for the 4-lane MAC
// Streams operand beats into the MAC registers, accumulates, then requantises the sum.
module mac_seq_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int OUT_WIDTH  = 32,
   parameter int LEN_WIDTH  = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   mac_seq_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, RUN, FLUSH, OUT} state_t;

   localparam logic signed [OUT_WIDTH-1:0] QMAX = (OUT_WIDTH'(1) <<< (DATA_WIDTH - 1)) - OUT_WIDTH'(1);
   localparam logic signed [OUT_WIDTH-1:0] QMIN = ~QMAX;

   state_t                         state;
   logic [LEN_WIDTH-1:0]           len_r;
   logic [LEN_WIDTH-1:0]           cnt;
   logic [4:0]                     shift_r;
   logic                           relu_r;
   logic                           mac_vld;
   logic signed [OUT_WIDTH-1:0]    acc;
   logic signed [OUT_WIDTH-1:0]    acc_next;
   logic                           busy_r;
   logic                           in_ready_r;
   logic                           out_valid_r;
   logic [4*DATA_WIDTH-1:0]        mac_a_r;
   logic [4*DATA_WIDTH-1:0]        mac_b_r;
   logic [OUT_WIDTH-1:0]           out_acc_r;
   logic [DATA_WIDTH-1:0]          out_q_r;

   function automatic logic [DATA_WIDTH-1:0] requant(
      input logic signed [OUT_WIDTH-1:0] s,
      input logic [4:0]                  sh,
      input logic                        rl
   );
      logic signed [OUT_WIDTH-1:0] v;
      logic signed [OUT_WIDTH-1:0] t;
      v = (rl && (s < 0)) ? '0 : s;
      t = v >>> sh;
      if (t > QMAX)
         t = QMAX;
      else if (t < QMIN)
         t = QMIN;
      return t[DATA_WIDTH-1:0];
   endfunction

   always_comb begin
      acc_next = acc;
      if (mac_vld)
         acc_next = acc + $signed(bus.mac_result);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         len_r       <= '0;
         cnt         <= '0;
         shift_r     <= '0;
         relu_r      <= 1'b0;
         mac_vld     <= 1'b0;
         acc         <= '0;
         busy_r      <= 1'b0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         mac_a_r     <= '0;
         mac_b_r     <= '0;
         out_acc_r   <= '0;
         out_q_r     <= '0;
      end else begin
         acc <= acc_next;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  len_r   <= bus.len;
                  shift_r <= bus.shift;
                  relu_r  <= bus.relu_en;
                  acc     <= '0;
                  cnt     <= '0;
                  mac_vld <= 1'b0;
                  busy_r  <= 1'b1;
                  if (bus.len != '0) begin
                     state      <= RUN;
                     in_ready_r <= 1'b1;
                  end else begin
                     state <= FLUSH;
                  end
               end
            end
            RUN: begin
               if (bus.in_valid && in_ready_r) begin
                  mac_a_r <= bus.in_a;
                  mac_b_r <= bus.in_b;
                  mac_vld <= 1'b1;
                  cnt     <= cnt + LEN_WIDTH'(1);
                  if (cnt == len_r - LEN_WIDTH'(1)) begin
                     state      <= FLUSH;
                     in_ready_r <= 1'b0;
                  end
               end else begin
                  mac_vld <= 1'b0;
               end
            end
            // The last beat's product lands in acc on this edge, so the result is taken from acc_next.
            FLUSH: begin
               mac_vld     <= 1'b0;
               out_acc_r   <= acc_next;
               out_q_r     <= requant(acc_next, shift_r, relu_r);
               out_valid_r <= 1'b1;
               state       <= OUT;
            end
            OUT: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_r;
   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.mac_a     = mac_a_r;
   assign bus.mac_b     = mac_b_r;
   assign bus.out_acc   = out_acc_r;
   assign bus.out_q     = out_q_r;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - scoreboard bench for mac_seq_ctrl with a behavioural 4-lane MAC
module tb_mac_seq_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mac_seq_ctrl_if #(.DATA_WIDTH(8), .OUT_WIDTH(32), .LEN_WIDTH(8)) bus();

   mac_seq_ctrl #(.DATA_WIDTH(8), .OUT_WIDTH(32), .LEN_WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] acc;
      logic [7:0]  q;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   logic signed [31:0] mac_sum;
   logic signed [7:0]  la;
   logic signed [7:0]  lb;

   // Combinational MAC datapath seen by the sequencer.
   always_comb begin
      mac_sum = '0;
      la = '0;
      lb = '0;
      for (int i = 0; i < 4; i++) begin
         la = bus.mac_a[8*i +: 8];
         lb = bus.mac_b[8*i +: 8];
         mac_sum = mac_sum + la * lb;
      end
      bus.mac_result = mac_sum;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, $signed(act), act, $signed(req), req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: got out_acc=%0d with empty scoreboard", $signed(bus.out_acc));
            end else begin
               e = sb.pop_front();
               check({e.name, "_acc"}, bus.out_acc, e.acc);
               check({e.name, "_q"}, 32'(bus.out_q), 32'(e.q));
            end
         end
      end
   end

   task automatic run_job(input string name, input int l, input int sh, input bit rl,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eacc, input logic [7:0] eq,
                          input logic [7:0] vpat, input int vlen, input bit chk_lat);
      int got = 0;
      int cyc = 0;
      int p = 0;
      bit took;
      sb.push_back('{eacc, eq, name});
      bus.start = 1'b1;
      bus.len = 8'(l);
      bus.shift = 5'(sh);
      bus.relu_en = rl;
      step();
      bus.start = 1'b0;
      check({name, "_busy"}, 32'(bus.busy), 32'd1);
      if (l > 0) begin
         while (got < l && cyc < 200) begin
            bus.in_valid = vpat[p % vlen];
            bus.in_a = a;
            bus.in_b = b;
            p++;
            @(negedge clk);
            took = bus.in_valid && bus.in_ready;
            step();
            cyc++;
            if (took)
               got++;
         end
         bus.in_valid = 1'b0;
         check({name, "_beats"}, got, l);
         if (chk_lat) begin
            check({name, "_ready_drop"}, 32'(bus.in_ready), 32'd0);
            check({name, "_valid_k1"}, 32'(bus.out_valid), 32'd0);
            step();
            check({name, "_valid_k2"}, 32'(bus.out_valid), 32'd1);
         end
      end
      cyc = 0;
      while (bus.busy && cyc < 200) begin
         step();
         cyc++;
      end
      check({name, "_idle"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      bus.start = 1'b0;
      bus.len = '0;
      bus.shift = '0;
      bus.relu_en = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_a = '0;
      bus.in_b = '0;
      bus.out_ready = 1'b1;
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_acc", bus.out_acc, 32'd0);
      check("rst_mac_a", bus.mac_a, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();

      run_job("dot70", 1, 0, 1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5},
              32'd70, 8'd70, 8'h01, 1, 1'b1);
      run_job("sat_pos", 3, 8, 1'b0, 32'h7f7f7f7f, 32'h7f7f7f7f,
              32'd193548, 8'h7f, 8'h01, 1, 1'b1);
      run_job("relu", 2, 0, 1'b1, 32'h80808080, 32'h7f7f7f7f,
              32'hfffe0400, 8'h00, 8'h01, 1, 1'b0);
      run_job("sat_neg", 2, 4, 1'b0, 32'h80808080, 32'h7f7f7f7f,
              32'hfffe0400, 8'h80, 8'h01, 1, 1'b0);
      run_job("shift2", 1, 2, 1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5},
              32'd70, 8'd17, 8'h01, 1, 1'b0);
      run_job("neg_shift", 1, 1, 1'b0, {8'hfc, 8'hfd, 8'hfe, 8'hff}, {8'd8, 8'd7, 8'd6, 8'd5},
              32'hffffffba, 8'hdd, 8'h01, 1, 1'b0);

      check("gaps_pre_ready", 32'(bus.in_ready), 32'd0);
      run_job("gaps", 4, 0, 1'b0, 32'h01010101, 32'h02020202,
              32'd32, 8'd32, 8'h59, 7, 1'b1);
      check("gaps_post_ready", 32'(bus.in_ready), 32'd0);

      // Zero-length job under backpressure with start pulses that must be ignored.
      sb.push_back('{32'd0, 8'd0, "len0"});
      bus.out_ready = 1'b0;
      bus.start = 1'b1;
      bus.len = 8'd0;
      bus.shift = 5'd0;
      bus.relu_en = 1'b0;
      step();
      bus.start = 1'b0;
      check("len0_flush_valid", 32'(bus.out_valid), 32'd0);
      step();
      check("len0_valid", 32'(bus.out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         bus.start = 1'b1;
         bus.len = 8'd1;
         step();
         check("len0_hold_valid", 32'(bus.out_valid), 32'd1);
         check("len0_hold_acc", bus.out_acc, 32'd0);
         check("len0_hold_q", 32'(bus.out_q), 32'd0);
         check("len0_hold_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      step();
      bus.start = 1'b0;
      check("len0_release_busy", 32'(bus.busy), 32'd0);
      check("len0_release_valid", 32'(bus.out_valid), 32'd0);
      step();
      check("len0_no_queued_start", 32'(bus.busy), 32'd0);

      // Asynchronous reset in the middle of a 5-beat job.
      bus.start = 1'b1;
      bus.len = 8'd5;
      step();
      bus.start = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_a = 32'h05050505;
      bus.in_b = 32'h03030303;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_in_ready", 32'(bus.in_ready), 32'd0);
      check("arst_out_valid", 32'(bus.out_valid), 32'd0);
      check("arst_mac_a", bus.mac_a, 32'd0);
      check("arst_mac_b", bus.mac_b, 32'd0);
      check("arst_out_acc", bus.out_acc, 32'd0);
      check("arst_out_q", 32'(bus.out_q), 32'd0);
      bus.in_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      run_job("post_reset", 1, 0, 1'b0, 32'h01010101, 32'h01010101,
              32'd4, 8'd4, 8'h01, 1, 1'b1);

      step();
      check("scoreboard_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
